blockram_read_arbiter: RTL and testbench

BLOCKRAM_READ_ARBITER -- requirements
Module: blockram_read_arbiter

---
 rtl/blockram_read_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_blockram_read_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blockram_read_arbiter.sv
// ---------------------------------------------------------------------------
// blockram_read_arbiter
// Shares the single read port of a block RAM among NUM_REQUESTER clients with
// round-robin arbitration. A grant in cycle T drives the RAM read in T. The
// RAM returns data in T+1, and the response is registered out in T+2 to the
// granted requester. Writes pass straight through to the RAM write port.
//
// Optional feature (macro BLOCKRAM_READ_ARBITER_WRITE_FORWARD_EN):
//   A write in cycle T that targets the granted read address has its masked
//   bytes merged into that read's response, so the reader sees the new data
//   instead of the RAM's read-first old data. When the macro is undefined the
//   RAM data is returned unmodified.
//
// Ports
//   clk_in, reset_in             clock, synchronous active-high reset
//   request_valid_in/addr_in     per-requester read request, flattened addrs
//   request_ready_out            one-hot grant (combinational)
//   response_valid_out           one-hot response strobe (registered)
//   response_data_out            response data, held between strobes
//   response_entry_valid_out     RAM valid bit accompanying the response
//   write_*_in                   writer port
//   ram_read_*                   RAM read port (1-cycle latency, read-first)
//   ram_write_*_out              combinational copy of write_*_in
// ---------------------------------------------------------------------------
`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

module blockram_read_arbiter #(
   parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 64,
   parameter int unsigned NUM_SET                    = 64,
   parameter int unsigned SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
   parameter int unsigned WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / `BYTE_LEN_IN_BITS,
   parameter int unsigned NUM_REQUESTER              = 4
) (
   input  logic                                             clk_in,
   input  logic                                             reset_in,

   input  logic [NUM_REQUESTER-1:0]                         request_valid_in,
   input  logic [NUM_REQUESTER*SET_PTR_WIDTH_IN_BITS-1:0]   request_addr_in,
   output logic [NUM_REQUESTER-1:0]                         request_ready_out,

   output logic [NUM_REQUESTER-1:0]                         response_valid_out,
   output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]            response_data_out,
   output logic                                             response_entry_valid_out,

   input  logic                                             write_en_in,
   input  logic [WRITE_MASK_LEN-1:0]                        write_mask_in,
   input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                 write_addr_in,
   input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]            write_data_in,

   output logic                                             ram_read_en_out,
   output logic [SET_PTR_WIDTH_IN_BITS-1:0]                 ram_read_addr_out,
   input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]            ram_read_data_in,
   input  logic                                             ram_read_valid_in,

   output logic                                             ram_write_en_out,
   output logic [WRITE_MASK_LEN-1:0]                        ram_write_mask_out,
   output logic [SET_PTR_WIDTH_IN_BITS-1:0]                 ram_write_addr_out,
   output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]            ram_write_data_out
);

   localparam int unsigned BYTE_W = `BYTE_LEN_IN_BITS;
   localparam int unsigned AW     = SET_PTR_WIDTH_IN_BITS;
   localparam int unsigned DW     = SINGLE_ENTRY_WIDTH_IN_BITS;
   localparam int unsigned MW     = WRITE_MASK_LEN;
   localparam int unsigned NR     = NUM_REQUESTER;
   localparam int unsigned PTR_W  = (NR > 1) ? $clog2(NR) : 1;

   // ------------------------------------------------------------------------
   // Arbitration state
   // ------------------------------------------------------------------------
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] grant_idx;
   logic [PTR_W-1:0] next_ptr;
   logic [PTR_W:0]   cand;
   logic [NR-1:0]    grant;
   logic             accept;

   // ------------------------------------------------------------------------
   // Pipeline state
   // ------------------------------------------------------------------------
   logic [NR-1:0]    s1_grant;
   logic [DW-1:0]    merged_data;
   logic             merged_valid;

   // Round-robin search: first valid requester at or after rr_ptr, with wrap.
   // Reset gates the grant so nothing is accepted during reset cycles.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      accept    = 1'b0;
      cand      = '0;
      if (!reset_in) begin
         for (int unsigned k = 0; k < NR; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NR)) begin
               cand = cand - (PTR_W+1)'(NR);
            end
            if (!accept && request_valid_in[cand[PTR_W-1:0]]) begin
               accept    = 1'b1;
               grant_idx = cand[PTR_W-1:0];
            end
         end
         if (accept) begin
            grant[grant_idx] = 1'b1;
         end
      end
   end

   // Pointer moves one past the winner so the winner becomes lowest priority.
   always_comb begin
      next_ptr = '0;
      if (grant_idx != PTR_W'(NR - 1)) begin
         next_ptr = grant_idx + PTR_W'(1);
      end
   end

   // Read address mux: slice of the granted requester.
   always_comb begin
      ram_read_addr_out = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         if (grant[i]) begin
            ram_read_addr_out = request_addr_in[i*AW +: AW];
         end
      end
   end

   assign request_ready_out = grant;
   assign ram_read_en_out   = (|request_valid_in) & ~reset_in;

   // Writes are independent of reads and go straight to the RAM.
   assign ram_write_en_out   = write_en_in;
   assign ram_write_mask_out = write_mask_in;
   assign ram_write_addr_out = write_addr_in;
   assign ram_write_data_out = write_data_in;

`ifdef BLOCKRAM_READ_ARBITER_WRITE_FORWARD_EN
   // ------------------------------------------------------------------------
   // Same-cycle write forwarding
   // ------------------------------------------------------------------------
   logic [MW-1:0] fwd_mask;
   logic [MW-1:0] s1_fwd_mask;
   logic [DW-1:0] s1_fwd_data;

   // A write colliding with the accepted read must be visible to that reader.
   always_comb begin
      fwd_mask = '0;
      if (accept && write_en_in && (write_addr_in == ram_read_addr_out)) begin
         fwd_mask = write_mask_in;
      end
   end

   // Capture the colliding write alongside stage 1.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         s1_fwd_mask <= '0;
         s1_fwd_data <= '0;
      end else begin
         s1_fwd_mask <= fwd_mask;
         s1_fwd_data <= write_data_in;
      end
   end

   // Overlay forwarded byte lanes onto the RAM's old data.
   always_comb begin
      merged_data = ram_read_data_in;
      for (int unsigned b = 0; b < MW; b++) begin
         if (s1_fwd_mask[b]) begin
            merged_data[b*BYTE_W +: BYTE_W] = s1_fwd_data[b*BYTE_W +: BYTE_W];
         end
      end
      merged_valid = ram_read_valid_in | (|s1_fwd_mask);
   end
`else
   // Without forwarding the reader sees read-first RAM data as is.
   always_comb begin
      merged_data  = ram_read_data_in;
      merged_valid = ram_read_valid_in;
   end
`endif

   // Pointer, stage 1 (RAM data cycle) and stage 2 (response cycle).
   // Reset drops anything in flight; data is held between strobes.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         rr_ptr                   <= '0;
         s1_grant                 <= '0;
         response_valid_out       <= '0;
         response_data_out        <= '0;
         response_entry_valid_out <= 1'b0;
      end else begin
         if (accept) begin
            rr_ptr <= next_ptr;
         end
         s1_grant           <= grant;
         response_valid_out <= s1_grant;
         if (|s1_grant) begin
            response_data_out        <= merged_data;
            response_entry_valid_out <= merged_valid;
         end
      end
   end

endmodule

// File: tb/tb_blockram_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_blockram_read_arbiter
// Directed bench for blockram_read_arbiter with default parameters. A small
// read-first RAM model sits on the RAM ports. A per-cycle reference model
// (round-robin pointer plus a two-slot response queue) is checked on every
// negative edge. Directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_blockram_read_arbiter;

   localparam int NR = 4;
   localparam int AW = 6;
   localparam int DW = 64;
   localparam int MW = 8;

   logic              clk_in = 1'b0;
   logic              reset_in;
   logic [NR-1:0]     request_valid_in;
   logic [NR*AW-1:0]  request_addr_in;
   logic [NR-1:0]     request_ready_out;
   logic [NR-1:0]     response_valid_out;
   logic [DW-1:0]     response_data_out;
   logic              response_entry_valid_out;
   logic              write_en_in;
   logic [MW-1:0]     write_mask_in;
   logic [AW-1:0]     write_addr_in;
   logic [DW-1:0]     write_data_in;
   logic              ram_read_en_out;
   logic [AW-1:0]     ram_read_addr_out;
   logic [DW-1:0]     ram_read_data_in = '0;
   logic              ram_read_valid_in = 1'b0;
   logic              ram_write_en_out;
   logic [MW-1:0]     ram_write_mask_out;
   logic [AW-1:0]     ram_write_addr_out;
   logic [DW-1:0]     ram_write_data_out;

   blockram_read_arbiter dut (
      .clk_in                   (clk_in),
      .reset_in                 (reset_in),
      .request_valid_in         (request_valid_in),
      .request_addr_in          (request_addr_in),
      .request_ready_out        (request_ready_out),
      .response_valid_out       (response_valid_out),
      .response_data_out        (response_data_out),
      .response_entry_valid_out (response_entry_valid_out),
      .write_en_in              (write_en_in),
      .write_mask_in            (write_mask_in),
      .write_addr_in            (write_addr_in),
      .write_data_in            (write_data_in),
      .ram_read_en_out          (ram_read_en_out),
      .ram_read_addr_out        (ram_read_addr_out),
      .ram_read_data_in         (ram_read_data_in),
      .ram_read_valid_in        (ram_read_valid_in),
      .ram_write_en_out         (ram_write_en_out),
      .ram_write_mask_out       (ram_write_mask_out),
      .ram_write_addr_out       (ram_write_addr_out),
      .ram_write_data_out       (ram_write_data_out)
   );

   always #5 clk_in = ~clk_in;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // Read-first RAM with one-cycle read latency and byte-masked writes
   // ------------------------------------------------------------------------
   logic [DW-1:0] mem  [64];
   logic          vmem [64];
   logic          loaded = 1'b0;

   always @(posedge clk_in) begin
      if (!loaded) begin
         for (int i = 0; i < 64; i++) begin
            mem[i]  <= {8{8'(i)}} ^ 64'h0123456789ABCDEF;
            vmem[i] <= 1'(i);
         end
         mem[9]  <= 64'h00000000000000A5;
         vmem[9] <= 1'b1;
         mem[5]  <= 64'h1122334455667788;
         vmem[5] <= 1'b0;
         loaded  <= 1'b1;
      end else begin
         if (ram_read_en_out) begin
            ram_read_data_in  <= mem[ram_read_addr_out];
            ram_read_valid_in <= vmem[ram_read_addr_out];
         end
         if (ram_write_en_out) begin
            for (int b = 0; b < MW; b++) begin
               if (ram_write_mask_out[b]) begin
                  mem[ram_write_addr_out][b*8 +: 8] <= ram_write_data_out[b*8 +: 8];
               end
            end
            if (|ram_write_mask_out) vmem[ram_write_addr_out] <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Reference model, checked on every falling edge, then advanced to the
   // state the next rising edge must produce.
   // ------------------------------------------------------------------------
   logic          model_init = 1'b0;
   int            m_ptr = 0;
   int            p1_req = -1, p2_req = -1;
   logic [DW-1:0] p1_data, p2_data;
   logic          p1_ev, p2_ev;
   logic [DW-1:0] exp_data = '0;
   logic          exp_ev = 1'b0;

   always @(negedge clk_in) begin
      int            g;
      int            idx;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          e;
      g = -1;
      if (!reset_in) begin
         for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (g < 0 && request_valid_in[idx]) g = idx;
         end
      end
      if (model_init) begin
         chk("grant", 128'(request_ready_out), 128'((g >= 0) ? (1 << g) : 0));
         chk("ram_read_en", 128'(ram_read_en_out), 128'(!reset_in && (request_valid_in != 0)));
         if (g >= 0) chk("ram_read_addr", 128'(ram_read_addr_out), 128'(request_addr_in[g*AW +: AW]));
         chk("resp_valid", 128'(response_valid_out), 128'((p2_req >= 0) ? (1 << p2_req) : 0));
         chk("resp_data", 128'(response_data_out), 128'(exp_data));
         if (p2_req >= 0) chk("resp_entry_valid", 128'(response_entry_valid_out), 128'(exp_ev));
         chk("write_pass",
             128'({ram_write_en_out, ram_write_mask_out, ram_write_addr_out, ram_write_data_out}),
             128'({write_en_in, write_mask_in, write_addr_in, write_data_in}));
      end
      if (reset_in) begin
         model_init = 1'b1;
         m_ptr      = 0;
         p1_req     = -1;
         p2_req     = -1;
         exp_data   = '0;
         exp_ev     = 1'b0;
      end else begin
         p2_req  = p1_req;
         p2_data = p1_data;
         p2_ev   = p1_ev;
         if (p2_req >= 0) begin
            exp_data = p2_data;
            exp_ev   = p2_ev;
         end
         p1_req = -1;
         if (g >= 0) begin
            a = request_addr_in[g*AW +: AW];
            d = mem[a];
            e = vmem[a];
`ifdef BLOCKRAM_READ_ARBITER_WRITE_FORWARD_EN
            if (write_en_in && write_addr_in == a) begin
               for (int b = 0; b < MW; b++) begin
                  if (write_mask_in[b]) d[b*8 +: 8] = write_data_in[b*8 +: 8];
               end
               if (write_mask_in != 0) e = 1'b1;
            end
`endif
            p1_req  = g;
            p1_data = d;
            p1_ev   = e;
            m_ptr   = (g + 1) % NR;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Directed stimulus
   // ------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_addr(input int r, input int a);
      request_addr_in[r*AW +: AW] = AW'(a);
   endtask

   logic [3:0] s1_grant_tab  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
   logic [3:0] s1_strobe_tab [6] = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
   int others;

   initial begin
      reset_in         = 1'b1;
      request_valid_in = '0;
      request_addr_in  = '0;
      write_en_in      = 1'b0;
      write_mask_in    = '0;
      write_addr_in    = '0;
      write_data_in    = '0;
      tick();
      tick();
      #1;
      chk("reset_resp_valid", 128'(response_valid_out), 128'(0));
      chk("reset_resp_data", 128'(response_data_out), 128'(0));
      chk("reset_entry_valid", 128'(response_entry_valid_out), 128'(0));
      reset_in = 1'b0;

      // All four requesters: grants 0..3, strobes two cycles later.
      for (int r = 0; r < NR; r++) set_addr(r, r + 1);
      for (int k = 0; k < 6; k++) begin
         request_valid_in = (k < 4) ? 4'b1111 : 4'b0000;
         #1;
         chk("s1_grant", 128'(request_ready_out), 128'(s1_grant_tab[k]));
         chk("s1_strobe", 128'(response_valid_out), 128'(s1_strobe_tab[k]));
         tick();
      end

      // Move pointer to 3, then requesters 1 and 3 only: 3 first, then 1.
      request_valid_in = 4'b0100;
      #1 chk("s2_setup", 128'(request_ready_out), 128'(4'b0100));
      tick();
      request_valid_in = 4'b1010;
      #1 chk("s2_wrap_first", 128'(request_ready_out), 128'(4'b1000));
      tick();
      chk("s2_wrap_second", 128'(request_ready_out), 128'(4'b0010));
      tick();
      request_valid_in = 4'b0000;

      // Requester 2 reads set 9 holding 0xA5 with entry valid.
      set_addr(2, 9);
      request_valid_in = 4'b0100;
      #1 chk("s3_grant", 128'(request_ready_out), 128'(4'b0100));
      tick();
      request_valid_in = 4'b0000;
      tick();
      chk("s3_strobe", 128'(response_valid_out), 128'(4'b0100));
      chk("s3_data", 128'(response_data_out), 128'(64'hA5));
      chk("s3_entry_valid", 128'(response_entry_valid_out), 128'(1));
      tick();

      // Same-cycle write of lane 0 and read of set 5.
      set_addr(0, 5);
      request_valid_in = 4'b0001;
      write_en_in      = 1'b1;
      write_mask_in    = 8'h01;
      write_addr_in    = 6'd5;
      write_data_in    = 64'hDEADBEEFCAFEBA77;
      #1 chk("s4_grant", 128'(request_ready_out), 128'(4'b0001));
      tick();
      request_valid_in = 4'b0000;
      write_en_in      = 1'b0;
      write_mask_in    = 8'h00;
      tick();
      chk("s4_strobe", 128'(response_valid_out), 128'(4'b0001));
`ifdef BLOCKRAM_READ_ARBITER_WRITE_FORWARD_EN
      chk("s4_data", 128'(response_data_out), 128'(64'h1122334455667777));
      chk("s4_entry_valid", 128'(response_entry_valid_out), 128'(1));
`else
      chk("s4_data", 128'(response_data_out), 128'(64'h1122334455667788));
      chk("s4_entry_valid", 128'(response_entry_valid_out), 128'(0));
`endif
      tick();

      // Reset right after an accept drops the response.
      set_addr(2, 3);
      request_valid_in = 4'b0100;
      tick();
      reset_in         = 1'b1;
      request_valid_in = 4'b1111;
      #1;
      chk("s5_ready_in_reset", 128'(request_ready_out), 128'(0));
      chk("s5_rd_en_in_reset", 128'(ram_read_en_out), 128'(0));
      tick();
      reset_in         = 1'b0;
      request_valid_in = 4'b0000;
      chk("s5_data_cleared", 128'(response_data_out), 128'(0));
      for (int k = 0; k < 3; k++) begin
         chk("s5_no_strobe", 128'(response_valid_out), 128'(0));
         tick();
      end
      request_valid_in = 4'b1111;
      #1 chk("s5_first_grant", 128'(request_ready_out), 128'(4'b0001));
      tick();
      request_valid_in = 4'b0000;
      tick();
      tick();
      tick();

      // Requester 1 held; others and writes random over a small address range.
      others = 0;
      for (int k = 0; k < 60; k++) begin
         request_valid_in = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             1'b1, 1'($urandom_range(0, 1))};
         for (int r = 0; r < NR; r++) set_addr(r, int'($urandom_range(0, 7)));
         write_en_in   = 1'($urandom_range(0, 1));
         write_mask_in = 8'($urandom_range(0, 255));
         write_addr_in = 6'($urandom_range(0, 7));
         write_data_in = {32'($urandom), 32'($urandom)};
         #1;
         if (request_ready_out[1]) others = 0;
         else if (request_ready_out != 0) others++;
         chk("s6_fairness", 128'(others <= NR - 1), 128'(1));
         tick();
      end
      request_valid_in = 4'b0000;
      write_en_in      = 1'b0;
      for (int k = 0; k < 4; k++) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
